// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA scan controller:
//   - default 640x480@60 timing values (pixel clock = clk_100MHz / 4)
//   - scan FSM state encoding
//   - packed bundle of the registered scan outputs
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int   DEF_H_ACTIVE = 640;
  localparam int   DEF_H_FP     = 16;
  localparam int   DEF_H_SYNC   = 96;
  localparam int   DEF_H_BP     = 48;
  localparam int   DEF_V_ACTIVE = 480;
  localparam int   DEF_V_FP     = 10;
  localparam int   DEF_V_SYNC   = 2;
  localparam int   DEF_V_BP     = 33;
  localparam int   DEF_DIV      = 4;
  localparam logic DEF_SYNC_POL = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } scan_state_e;

  // Every registered output except pix_ce, grouped so one register holds them.
  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       line_start;
    logic       frame_start;
    logic       vblank_start;
    logic       running;
  } scan_out_t;

endpackage

// File: rtl/pix_ce_gen.sv
// ---------------------------------------------------------------------------
// pix_ce_gen
// Free-running modulo-DIV divider producing a one-cycle pixel strobe.
// Ports:
//   clk_100MHz : system clock
//   reset      : asynchronous active-high reset (counter cleared, strobe low)
//   pix_ce     : high for one clk_100MHz cycle out of every DIV
// After reset release the strobe is first sampled high on the DIV-th edge.
// ---------------------------------------------------------------------------
module pix_ce_gen #(
  parameter int DIV = 4
) (
  input  logic clk_100MHz,
  input  logic reset,
  output logic pix_ce
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_r;

  // Divider counter, wraps at DIV-1.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      div_cnt_r <= '0;
    end else if (div_cnt_r == LAST) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + CW'(1);
    end
  end

  // Reset gating keeps the strobe low during reset even when DIV is 1.
  assign pix_ce = ~reset & (div_cnt_r == LAST);

endmodule

// File: rtl/vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// vga_scan_ctrl
// VGA raster scan controller with IDLE / RUN / DRAIN sequencing.
// Ports:
//   clk_100MHz   : system clock
//   reset        : asynchronous active-high reset
//   enable       : level request to scan; dropping it lets the frame finish
//   pix_ce       : pixel strobe (combinational decode of the divider)
//   hsync, vsync : sync outputs, active level SYNC_POL
//   video_on     : high inside the visible area
//   pix_x, pix_y : visible coordinates, 0 outside the visible area
//   line_start, frame_start, vblank_start : one-clk event pulses
//   running      : FSM is not IDLE
// All outputs except pix_ce are registered and decoded from the counter
// values being loaded on the same pix_ce edge.
// ---------------------------------------------------------------------------
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   DIV      = DEF_DIV,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       enable,
  output logic       pix_ce,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       line_start,
  output logic       frame_start,
  output logic       vblank_start,
  output logic       running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam scan_out_t IDLE_OUT = '{
    hsync:        ~SYNC_POL,
    vsync:        ~SYNC_POL,
    video_on:     1'b0,
    pix_x:        10'd0,
    pix_y:        10'd0,
    line_start:   1'b0,
    frame_start:  1'b0,
    vblank_start: 1'b0,
    running:      1'b0
  };

  logic          pix_ce_s;
  scan_state_e   state_r, state_s;
  logic [HW-1:0] h_cnt_r, h_inc_s, h_nxt_s;
  logic [VW-1:0] v_cnt_r, v_inc_s, v_nxt_s;
  logic          frame_end_s;
  logic          active_s;
  logic          visible_s;
  scan_out_t     out_r, out_s;

  pix_ce_gen #(.DIV(DIV)) u_pix_ce_gen (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .pix_ce     (pix_ce_s)
  );

  // Raster advance: next position if the scan simply moves on one pixel.
  always_comb begin
    h_inc_s     = (h_cnt_r == H_LAST) ? '0 : h_cnt_r + HW'(1);
    v_inc_s     = v_cnt_r;
    frame_end_s = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
    if (h_cnt_r == H_LAST) begin
      v_inc_s = (v_cnt_r == V_LAST) ? '0 : v_cnt_r + VW'(1);
    end else begin
      v_inc_s = v_cnt_r;
    end
  end

  // Next-state logic; active_s says whether the scan is live after the edge.
  always_comb begin
    state_s  = state_r;
    h_nxt_s  = h_inc_s;
    v_nxt_s  = v_inc_s;
    active_s = 1'b1;
    case (state_r)
      ST_IDLE: begin
        h_nxt_s = '0;
        v_nxt_s = '0;
        if (enable) begin
          state_s = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
          active_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (enable) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // enable wins over the final wrap, so a restart loses no frame.
        if (enable) begin
          state_s = ST_RUN;
        end else if (frame_end_s) begin
          state_s  = ST_IDLE;
          active_s = 1'b0;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        h_nxt_s  = '0;
        v_nxt_s  = '0;
        active_s = 1'b0;
      end
    endcase
  end

  // Output decode from the post-edge counter values.
  always_comb begin
    out_s     = IDLE_OUT;
    visible_s = (h_nxt_s < H_VIS) && (v_nxt_s < V_VIS);
    if (active_s) begin
      out_s.hsync        = ((h_nxt_s >= H_SYNC_LO) && (h_nxt_s <= H_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
      out_s.vsync        = ((v_nxt_s >= V_SYNC_LO) && (v_nxt_s <= V_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
      out_s.video_on     = visible_s;
      out_s.pix_x        = visible_s ? 10'(h_nxt_s) : 10'd0;
      out_s.pix_y        = visible_s ? 10'(v_nxt_s) : 10'd0;
      out_s.line_start   = (h_nxt_s == '0);
      out_s.frame_start  = (h_nxt_s == '0) && (v_nxt_s == '0);
      out_s.vblank_start = (h_nxt_s == '0) && (v_nxt_s == V_VIS);
      out_s.running      = 1'b1;
    end else begin
      out_s = IDLE_OUT;
    end
  end

  // FSM state and raster counters, advanced only on pixel strobes.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (pix_ce_s) begin
      state_r <= state_s;
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
    end else begin
      state_r <= state_r;
      h_cnt_r <= h_cnt_r;
      v_cnt_r <= v_cnt_r;
    end
  end

  // Output register; event pulses last one clk_100MHz cycle only.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      out_r <= IDLE_OUT;
    end else if (pix_ce_s) begin
      out_r <= out_s;
    end else begin
      out_r.line_start   <= 1'b0;
      out_r.frame_start  <= 1'b0;
      out_r.vblank_start <= 1'b0;
    end
  end

  assign pix_ce       = pix_ce_s;
  assign hsync        = out_r.hsync;
  assign vsync        = out_r.vsync;
  assign video_on     = out_r.video_on;
  assign pix_x        = out_r.pix_x;
  assign pix_y        = out_r.pix_y;
  assign line_start   = out_r.line_start;
  assign frame_start  = out_r.frame_start;
  assign vblank_start = out_r.vblank_start;
  assign running      = out_r.running;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_ctrl
// Self-checking bench for vga_scan_ctrl using a reduced raster (15 x 10
// pixels, DIV 4) so several frames fit in a short run. The reference model
// tracks the scan as a linear pixel position within the frame and derives
// every expected output from that position with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_scan_ctrl;

  localparam int   HA  = 8;
  localparam int   HFP = 2;
  localparam int   HS  = 3;
  localparam int   HBP = 2;
  localparam int   VA  = 6;
  localparam int   VFP = 1;
  localparam int   VS  = 2;
  localparam int   VBP = 1;
  localparam int   DIV = 4;
  localparam logic POL = 1'b0;
  localparam int   HT  = HA + HFP + HS + HBP;
  localparam int   VT  = VA + VFP + VS + VBP;
  localparam int   FT  = HT * VT;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       enable     = 1'b0;
  logic       pix_ce, hsync, vsync, video_on;
  logic [9:0] pix_x, pix_y;
  logic       line_start, frame_start, vblank_start, running;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int         m_mode  = M_IDLE;
  int         m_pos   = 0;
  int         m_edges = 0;
  logic       e_hs, e_vs, e_vo, e_ls, e_fs, e_vb, e_run;
  logic [9:0] e_x, e_y;

  vga_scan_ctrl #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .DIV (DIV), .SYNC_POL (POL)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .reset        (reset),
    .enable       (enable),
    .pix_ce       (pix_ce),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_on     (video_on),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .vblank_start (vblank_start),
    .running      (running)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic idle_exp();
    e_hs = ~POL; e_vs = ~POL; e_vo = 1'b0; e_x = 10'd0; e_y = 10'd0;
    e_ls = 1'b0; e_fs = 1'b0; e_vb = 1'b0; e_run = 1'b0;
  endtask

  task automatic scan_exp();
    int h, v;
    h     = m_pos % HT;
    v     = m_pos / HT;
    e_hs  = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
    e_vs  = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
    e_vo  = (h < HA) && (v < VA);
    e_x   = e_vo ? 10'(h) : 10'd0;
    e_y   = e_vo ? 10'(v) : 10'd0;
    e_ls  = (h == 0);
    e_fs  = (m_pos == 0);
    e_vb  = (m_pos == VA * HT);
    e_run = 1'b1;
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_mode  = M_IDLE;
    m_pos   = 0;
    idle_exp();
  endtask

  // One rising edge of the reference: scan progresses a pixel per strobe.
  task automatic model_edge();
    bit ce;
    if (reset) begin
      model_reset();
    end else begin
      m_edges++;
      ce   = (m_edges % DIV == 0);
      e_ls = 1'b0; e_fs = 1'b0; e_vb = 1'b0;
      if (ce) begin
        if (m_mode == M_IDLE) begin
          if (enable) begin m_mode = M_RUN; m_pos = 0; end
        end else if (m_mode == M_RUN) begin
          m_pos = (m_pos + 1) % FT;
          if (!enable) m_mode = M_DRAIN;
        end else begin
          m_pos = (m_pos + 1) % FT;
          if (enable) m_mode = M_RUN;
          else if (m_pos == 0) m_mode = M_IDLE;
        end
        if (m_mode == M_IDLE) idle_exp();
        else scan_exp();
      end
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t pos=%0d", tag, obs, exp, $time, m_pos);
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t pos=%0d", tag, obs, exp, $time, m_pos);
    end
  endtask

  task automatic check_all();
    chk1 ("pix_ce",       pix_ce,       !reset && ((m_edges + 1) % DIV == 0));
    chk1 ("hsync",        hsync,        e_hs);
    chk1 ("vsync",        vsync,        e_vs);
    chk1 ("video_on",     video_on,     e_vo);
    chk10("pix_x",        pix_x,        e_x);
    chk10("pix_y",        pix_y,        e_y);
    chk1 ("line_start",   line_start,   e_ls);
    chk1 ("frame_start",  frame_start,  e_fs);
    chk1 ("vblank_start", vblank_start, e_vb);
    chk1 ("running",      running,      e_run);
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    model_edge();
    @(negedge clk_100MHz);
    check_all();
  endtask

  // Step until the model reaches the given mode and position, bounded.
  task automatic run_to(input int mode_req, input int pos_req);
    int n;
    n = 0;
    while (!(m_mode == mode_req && m_pos == pos_req) && n < 3 * FT * DIV) begin
      step();
      n++;
    end
    vectors++;
    assert (m_mode == mode_req && m_pos == pos_req) else begin
      miscompares++;
      $error("FAIL run_to observed mode=%0d pos=%0d expected mode=%0d pos=%0d", m_mode, m_pos, mode_req, pos_req);
    end
  endtask

  initial begin
    model_reset();
    // reset held: all outputs at idle values
    repeat (3) step();
    // release with enable: first strobe on edge DIV, frame_start with it
    reset  = 1'b0;
    enable = 1'b1;
    repeat (2 * FT * DIV + 40) step();
    // drop enable mid-frame, re-raise while draining
    run_to(M_RUN, 3 * HT);
    enable = 1'b0;
    run_to(M_DRAIN, 5 * HT + 4);
    enable = 1'b1;
    // drain completely to idle, then linger in idle
    run_to(M_RUN, 2 * HT);
    enable = 1'b0;
    run_to(M_IDLE, 0);
    repeat (40) step();
    // enable returns exactly on the final drain wrap
    enable = 1'b1;
    run_to(M_RUN, HT);
    enable = 1'b0;
    run_to(M_DRAIN, FT - 1);
    enable = 1'b1;
    repeat (4 * DIV) step();
    // random enable activity
    repeat (3000) begin
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      step();
    end
    // reset in the middle of a frame
    enable = 1'b1;
    run_to(M_RUN, 4 * HT + 9);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) step();
    reset = 1'b0;
    repeat (FT * DIV + 20) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACTIVE 640 visible px; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; DIV 4 clk_100MHz cycles per pixel; SYNC_POL 0 active sync level.
REQ-002 Reset SHALL be reset, asynchronous, active-high, and the clock SHALL be clk_100MHz.
REQ-003 Port clk_100MHz SHALL be an input of width 1 carrying the system clock.
REQ-004 Port reset SHALL be an input of width 1 carrying the asynchronous active-high reset.
REQ-005 Port enable SHALL be an input of width 1 that requests scanning; it SHALL be level-sensitive and synchronous to clk_100MHz.
REQ-006 Port pix_ce SHALL be an output of width 1 giving a one-cycle pixel strobe.
REQ-007 Ports hsync and vsync SHALL be outputs of width 1 carrying the sync signals.
REQ-008 Port video_on SHALL be an output of width 1 that is high only inside the visible area.
REQ-009 Ports pix_x and pix_y SHALL be outputs of width 10 giving the visible-pixel coordinates.
REQ-010 Ports line_start, frame_start and vblank_start SHALL be outputs of width 1 carrying one-clk_100MHz-cycle event pulses.
REQ-011 Port running SHALL be an output of width 1 that is high when the FSM is not IDLE.

Function
REQ-012 The divider counter SHALL be free-running modulo DIV, SHALL be 0 at reset, and SHALL assert pix_ce exactly when its value equals DIV-1; pix_ce SHALL be independent of FSM state.
REQ-013 h_cnt SHALL count 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1, where H_TOTAL is the sum of the H_* parameters (800 at default values) and V_TOTAL the sum of the V_* parameters (525).
REQ-014 Counters SHALL change only on edges where pix_ce=1 and the FSM state is RUN or DRAIN.
REQ-015 h_cnt SHALL wrap from H_TOTAL-1 to 0; on that wrap v_cnt SHALL increment, and v_cnt SHALL wrap from V_TOTAL-1 to 0.
REQ-016 All outputs except pix_ce SHALL be registered and updated on the same edge as the counters, decoded from the post-edge counter values.
REQ-017 hsync SHALL equal SYNC_POL while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] and ~SYNC_POL otherwise; vsync SHALL follow the same rule with the V_* parameters.
REQ-018 video_on SHALL equal (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE); pix_x and pix_y SHALL equal h_cnt and v_cnt when video_on=1 and SHALL be 0 otherwise.
REQ-019 line_start SHALL pulse for one clk on the edge where h_cnt becomes 0.
REQ-020 frame_start SHALL pulse for one clk on the edge where h_cnt and v_cnt both become 0.
REQ-021 vblank_start SHALL pulse for one clk on the edge where v_cnt becomes V_ACTIVE and h_cnt becomes 0.
REQ-022 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-023 From IDLE, when enable=1 on a pix_ce edge, the FSM SHALL go to RUN with counters at 0, and frame_start and line_start SHALL pulse on that edge.
REQ-024 In RUN, enable=0 SHALL move the FSM to DRAIN.
REQ-025 In DRAIN, the current frame SHALL complete; at the wrap from (H_TOTAL-1, V_TOTAL-1) the FSM SHALL go to IDLE, counters SHALL be 0, and no frame_start SHALL be issued.
REQ-026 In DRAIN, enable=1 SHALL return the FSM to RUN with no counter disturbance.
REQ-027 If enable changes on the same edge as the final wrap in DRAIN, enable=1 SHALL win and the FSM SHALL go to RUN with frame_start.
REQ-028 In IDLE, hsync and vsync SHALL be ~SYNC_POL, video_on and the pulse outputs SHALL be 0, pix_x and pix_y SHALL be 0, and running SHALL be 0.

Reset
REQ-029 Asserting reset SHALL immediately force the divider, h_cnt and v_cnt to 0, the FSM to IDLE, and all outputs to their IDLE values with pix_ce=0, including mid-frame.
REQ-030 After reset deasserts, the first pix_ce SHALL occur on the DIV-th rising edge of clk_100MHz.

Structure
REQ-031 The timing parameters' default values and the FSM state encoding SHALL reside in a shared package vga_timing_pkg.
REQ-032 The divider SHALL be a sub-module pix_ce_gen (parameter DIV; ports clk_100MHz, reset, pix_ce).
REQ-033 The total implementation SHALL be a single always block per register group, with no derived clocks.

Verification
REQ-034 Scenario: release reset with enable=1 -> pix_ce first on clk edge 4, then every 4 clks; frame_start and running rise on the first pix_ce edge.
REQ-035 Scenario: run one line -> hsync low for exactly 96 pixels (384 clks) starting at h_cnt=656; line_start period equals 3200 clks; video_on high for 640 pixels.
REQ-036 Scenario: run two frames -> frame_start period equals 1,680,000 clks; vsync low for lines 490..491; vblank_start at v_cnt=480, h_cnt=0.
REQ-037 Scenario: drop enable at v_cnt=100 -> DRAIN, scanning continues to (799,524), then IDLE with no further frame_start and running=0.
REQ-038 Scenario: in DRAIN, re-raise enable at v_cnt=300 -> RUN, next frame_start exactly one frame period after the previous one.
REQ-039 Scenario: assert reset at h_cnt=400, v_cnt=200 -> all outputs immediately at IDLE values; after release with enable=1, a clean restart per REQ-034.
